// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Streams a program into the mini-MIPS instruction memory. Bytes
//            arrive over a valid/ready handshake, four bytes (MSB first) form
//            one 32-bit instruction, and each instruction is written to
//            consecutive word addresses starting at 0. The core is held in
//            reset until the requested number of words has been written.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, all logic on rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin a load (honoured only when idle or done)
//   num_words  in   words to load, sampled with an accepted start
//   in_valid   in   in_data carries a program byte
//   in_data    in   program byte, MSB of each word first
//   in_ready   out  loader accepts a byte this cycle
//   mem_we     out  instruction-memory write strobe, one cycle per word
//   mem_addr   out  word address of the write
//   mem_wdata  out  assembled instruction word
//   busy       out  load in progress
//   done       out  load complete, core released
//   cpu_reset  out  reset to the processor core
//   checksum   out  XOR of every byte accepted in the current load
// ============================================================================
module program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_reset,
    output logic [7:0]            checksum
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RECV  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Largest loadable count: the whole memory.
    localparam logic [ADDR_WIDTH:0] c_MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]            r_state,      w_state_next;
    logic [ADDR_WIDTH:0]   r_count,      w_count_next;
    logic [ADDR_WIDTH:0]   r_words_done, w_words_done_next;
    logic [ADDR_WIDTH-1:0] r_addr,       w_addr_next;
    logic [1:0]            r_byte_cnt,   w_byte_cnt_next;
    // Only the first three bytes need storage; the fourth is merged directly
    // into the write data on the cycle it is accepted.
    logic [23:0]           r_word,       w_word_next;
    logic [7:0]            r_checksum,   w_checksum_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr,   w_mem_addr_next;
    logic [31:0]           r_mem_wdata,  w_mem_wdata_next;
    logic [31:0]           w_word_shift;

    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_words_done_next = r_words_done;
        w_addr_next       = r_addr;
        w_byte_cnt_next   = r_byte_cnt;
        w_word_next       = r_word;
        w_checksum_next   = r_checksum;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_word_shift      = {r_word, in_data};

        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    // Counts beyond the memory size are clamped to a full load.
                    w_count_next      = num_words[ADDR_WIDTH] ? c_MAX_WORDS : num_words;
                    w_words_done_next = '0;
                    w_addr_next       = '0;
                    w_byte_cnt_next   = '0;
                    w_word_next       = '0;
                    w_checksum_next   = '0;
                    w_state_next      = (num_words == '0) ? c_DONE : c_RECV;
                end
            end
            c_RECV: begin
                if (in_valid) begin
                    w_word_next     = w_word_shift[23:0];
                    w_checksum_next = r_checksum ^ in_data;
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        // Register the write now so address and data stay
                        // stable after the strobe drops.
                        w_mem_addr_next  = r_addr;
                        w_mem_wdata_next = w_word_shift;
                        w_state_next     = c_WRITE;
                    end
                end
            end
            c_WRITE: begin
                // The address wraps naturally after a full-memory load; the
                // count comparison below stops further writes.
                w_addr_next       = r_addr + 1'b1;
                w_words_done_next = r_words_done + 1'b1;
                w_state_next      = (w_words_done_next == r_count) ? c_DONE : c_RECV;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_count      <= '0;
            r_words_done <= '0;
            r_addr       <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_checksum   <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_words_done <= w_words_done_next;
            r_addr       <= w_addr_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_word       <= w_word_next;
            r_checksum   <= w_checksum_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
        end
    end

    // Handshake and status are decoded from state only, so in_ready never
    // depends combinationally on in_valid.
    assign in_ready  = (r_state == c_RECV);
    assign mem_we    = (r_state == c_WRITE);
    assign busy      = (r_state == c_RECV) || (r_state == c_WRITE);
    assign done      = (r_state == c_DONE);
    assign cpu_reset = (r_state != c_DONE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign checksum  = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Self-checking bench for program_loader. Stimulus queues the
//            expected memory writes; an independent monitor pops and compares
//            them whenever the write strobe is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   num_words;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          cpu_reset;
    logic [7:0]    checksum;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .cpu_reset (cpu_reset),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [AW+31:0] exp_q[$];   // {addr, data} of each expected write
    logic [7:0]     pend[$];    // fixed bytes to use before random ones
    logic [7:0]     m_csum;     // reference checksum of the current load
    logic [AW+31:0] e;
    bit             tog;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, required no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[AW+31:32]));
                check("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    // Offers one byte until accepted; with gaps, in_valid alternates 1/0.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        bit sent;
        guard = 0;
        sent  = 0;
        while (!sent && guard < 40) begin
            tog = ~tog;
            if (gaps && tog) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                sent     = (in_ready === 1'b1);
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (!sent) begin
            n_checks++;
            n_errors++;
            $display("FAIL byte_timeout: byte %0h not accepted within %0d cycles", b, guard);
        end else begin
            m_csum = m_csum ^ b;
            check("checksum_step", 32'(checksum), 32'(m_csum));
        end
    endtask

    // Complete load of nw words; poke pulses an extra start during word 1.
    task automatic load(input int nw, input bit gaps, input bit poke);
        int         cnt;
        logic [7:0] b[4];
        cnt = (nw > (1 << AW)) ? (1 << AW) : nw;
        start     = 1'b1;
        num_words = nw[AW:0];
        m_csum    = 8'h00;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",      32'(busy),      32'(cnt != 0));
        check("start_in_ready",  32'(in_ready),  32'(cnt != 0));
        check("start_done",      32'(done),      32'(cnt == 0));
        check("start_cpu_reset", 32'(cpu_reset), 32'(cnt != 0));
        check("start_checksum",  32'(checksum),  32'h0);
        for (int w = 0; w < cnt; w++) begin
            if (poke && w == 1) begin
                start     = 1'b1;
                num_words = 3'd1;
                @(negedge clk);
                start = 1'b0;
                check("poke_still_busy", 32'(busy), 32'h1);
            end
            for (int i = 0; i < 4; i++)
                b[i] = (pend.size() != 0) ? pend.pop_front() : 8'($urandom_range(0, 255));
            exp_q.push_back({AW'(w), b[0], b[1], b[2], b[3]});
            for (int i = 0; i < 4; i++) send_byte(b[i], gaps);
            check("write_in_ready_low", 32'(in_ready), 32'h0);
            check("write_strobe",       32'(mem_we),   32'h1);
            @(negedge clk);
            if (w == cnt - 1) begin
                check("end_done",      32'(done),      32'h1);
                check("end_cpu_reset", 32'(cpu_reset), 32'h0);
            end else begin
                check("next_in_ready", 32'(in_ready), 32'h1);
            end
        end
        repeat (2) @(negedge clk);
        check("hold_done",     32'(done),     32'h1);
        check("hold_busy",     32'(busy),     32'h0);
        check("hold_checksum", 32'(checksum), 32'(m_csum));
        check("hold_no_we",    32'(mem_we),   32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_words = '0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        tog       = 1'b0;
        m_csum    = 8'h00;

        // Reset held for three cycles with in_valid asserted.
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        check("rst_mem_we",    32'(mem_we),    32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", mem_wdata,      32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_done",      32'(done),      32'h0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        check("rst_checksum",  32'(checksum),  32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ignores_valid", 32'(checksum), 32'h0);
        check("idle_in_ready",      32'(in_ready), 32'h0);
        in_valid = 1'b0;

        // Two-word load with known bytes.
        pend = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        load(2, 1'b0, 1'b0);
        check("two_word_checksum", 32'(checksum), 32'h2D);

        // Backpressure / gaps.
        pend = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load(1, 1'b1, 1'b0);
        check("gap_checksum", 32'(checksum), 32'h00);

        // Zero count.
        load(0, 1'b0, 1'b0);

        // Reset in the middle of word 1 of a three-word load.
        start     = 1'b1;
        num_words = 3'd3;
        m_csum    = 8'h00;
        @(negedge clk);
        start = 1'b0;
        pend = '{8'h12, 8'h34, 8'h56, 8'h78};
        exp_q.push_back({AW'(0), 32'h12345678});
        for (int i = 0; i < 4; i++) send_byte(pend.pop_front(), 1'b0);
        @(negedge clk);
        send_byte(8'h9A, 1'b0);
        send_byte(8'hBC, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_cpu_reset", 32'(cpu_reset), 32'h1);
        check("mid_rst_busy",      32'(busy),      32'h0);
        check("mid_rst_in_ready",  32'(in_ready),  32'h0);
        check("mid_rst_checksum",  32'(checksum),  32'h0);
        check("mid_rst_mem_addr",  32'(mem_addr),  32'h0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_rst_idle_done", 32'(done), 32'h0);
        check("mid_rst_no_pending", 32'(exp_q.size()), 32'h0);

        // Full-memory load with wrap and an ignored start.
        load(4, 1'b0, 1'b1);
        // Oversized count clamps to a full load.
        load(7, 1'b0, 1'b0);
        // Restart from DONE.
        load(1, 1'b0, 1'b0);

        // Randomized loads.
        repeat (8) load(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
